// File: rtl/dhash_reader_9x8.sv
// ==========================================================================
// dhash_reader_9x8 : reads the 9x8 downscaled frame from BRAM and builds its
// 64-bit difference hash, handed off over valid/ready.        Rev 1.0
// ==========================================================================
`default_nettype none

module dhash_reader_9x8 #(
   parameter int PIX_WIDTH  = 8,
   parameter int TARGET_X   = 9,
   parameter int TARGET_Y   = 8,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [PIX_WIDTH-1:0]                 rd_data,
   output logic                                 rd_en,
   output logic [ADDR_WIDTH-1:0]                rd_addr,
   output logic                                 busy,
   output logic [TARGET_Y*(TARGET_X-1)-1:0]     hash,
   output logic                                 hash_valid,
   input  logic                                 hash_ready
);

   localparam int HASH_WIDTH = TARGET_Y * (TARGET_X - 1);
   localparam int COL_W      = $clog2(TARGET_X);
   localparam int ROW_W      = $clog2(TARGET_Y);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(TARGET_X - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(TARGET_Y - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [COL_W-1:0]        col_q, col_d;
   logic [ROW_W-1:0]        row_q, row_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    rd_en_q, rd_en_d;
   logic                    vld_q, vld_d;
   logic [COL_W-1:0]        tag_col_q, tag_col_d;
   logic [PIX_WIDTH-1:0]    prev_q, prev_d;
   logic [HASH_WIDTH-1:0]   part_q, part_d;
   logic [HASH_WIDTH-1:0]   hash_q, hash_d;

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      addr_d    = addr_q;
      rd_en_d   = rd_en_q;
      vld_d     = rd_en_q;
      tag_col_d = col_q;
      prev_d    = prev_q;
      part_d    = part_q;
      hash_d    = hash_q;

      // Hash bits arrive in index order 0..63, so shifting in from the top
      // lands every bit at r*(TARGET_X-1)+(c-1) once the frame is complete.
      if (vld_q) begin
         if (tag_col_q != '0) begin
            part_d = {(prev_q > rd_data), part_q[HASH_WIDTH-1:1]};
         end
         prev_d = rd_data;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               rd_en_d = 1'b1;
               addr_d  = '0;
               col_d   = '0;
               row_d   = '0;
               part_d  = '0;
            end
         end
         READ: begin
            if (col_q == LAST_COL && row_q == LAST_ROW) begin
               state_d = DRAIN;
               rd_en_d = 1'b0;
               addr_d  = '0;
               col_d   = '0;
               row_d   = '0;
            end else begin
               addr_d = addr_q + ADDR_WIDTH'(1);
               if (col_q == LAST_COL) begin
                  col_d = '0;
                  row_d = row_q + ROW_W'(1);
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         DRAIN: begin
            // Wait until the final read's data has been folded in.
            if (!vld_q) begin
               state_d = DONE;
               hash_d  = part_q;
            end
         end
         DONE: begin
            if (hash_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         col_q     <= '0;
         row_q     <= '0;
         addr_q    <= '0;
         rd_en_q   <= 1'b0;
         vld_q     <= 1'b0;
         tag_col_q <= '0;
         prev_q    <= '0;
         part_q    <= '0;
         hash_q    <= '0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         addr_q    <= addr_d;
         rd_en_q   <= rd_en_d;
         vld_q     <= vld_d;
         tag_col_q <= tag_col_d;
         prev_q    <= prev_d;
         part_q    <= part_d;
         hash_q    <= hash_d;
      end
   end

   assign rd_en      = rd_en_q;
   assign rd_addr    = addr_q;
   assign busy       = (state_q != IDLE);
   assign hash       = hash_q;
   assign hash_valid = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_dhash_reader_9x8.sv
// ==========================================================================
// tb_dhash_reader_9x8 : directed bench for dhash_reader_9x8 with a BRAM model.
// ==========================================================================
`default_nettype none

module tb_dhash_reader_9x8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rd_data = 8'h00;
   logic        rd_en;
   logic [6:0]  rd_addr;
   logic        busy;
   logic [63:0] hash;
   logic        hash_valid;
   logic        hash_ready = 1'b0;

   logic [7:0]  mem [0:71];
   int          n_vec  = 0;
   int          n_miss = 0;

   localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] BUMP     = 64'h0000_0000_1000_0000;

   dhash_reader_9x8 #(
      .PIX_WIDTH (8),
      .TARGET_X  (9),
      .TARGET_Y  (8),
      .ADDR_WIDTH(7)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rd_data   (rd_data),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .busy      (busy),
      .hash      (hash),
      .hash_valid(hash_valid),
      .hash_ready(hash_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // 0: all zero, 1: rows 255-10*c, 2: all 100 with p[3][4]=200, 3: all 77
   task automatic load(input int mode);
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 9; c++) begin
            case (mode)
               0: mem[r*9+c] = 8'd0;
               1: mem[r*9+c] = 8'(255 - 10*c);
               2: mem[r*9+c] = (r == 3 && c == 4) ? 8'd200 : 8'd100;
               default: mem[r*9+c] = 8'd77;
            endcase
         end
      end
   endtask

   // Called just after a negedge; returns just after the negedge following E+74.
   task automatic run_frame(input string name, input logic [63:0] exp_hash,
                            input logic [63:0] prev_hash);
      int bad = 0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 72; k++) begin
         @(negedge clk);
         if (!(rd_en === 1'b1 && rd_addr === 7'(k) && busy === 1'b1 && hash_valid === 1'b0))
            bad++;
         if (k == 36) chk({name, "_hash_held"}, hash, prev_hash);
      end
      chk({name, "_addr_seq_bad"}, 64'(bad), 64'd0);
      @(negedge clk);
      chk({name, "_drain_rd_en"}, {63'd0, rd_en}, 64'd0);
      chk({name, "_valid_e73"}, {63'd0, hash_valid}, 64'd0);
      @(negedge clk);
      chk({name, "_valid_e74m"}, {63'd0, hash_valid}, 64'd0);
      @(negedge clk);
      chk({name, "_valid_e74"}, {63'd0, hash_valid}, 64'd1);
      chk({name, "_hash"}, hash, exp_hash);
   endtask

   task automatic accept(input string name, input logic with_start);
      hash_ready = 1'b1;
      start      = with_start;
      @(negedge clk);
      hash_ready = 1'b0;
      start      = 1'b0;
      chk({name, "_acc_valid"}, {63'd0, hash_valid}, 64'd0);
      chk({name, "_acc_busy"}, {63'd0, busy}, 64'd0);
      chk({name, "_acc_rd_en"}, {63'd0, rd_en}, 64'd0);
   endtask

   initial begin
      int bad;
      logic found;
      load(0);
      #1 rst = 1'b0;
      #1;
      chk("rst_outputs", {rd_en, rd_addr, busy, hash_valid}, 64'd0);
      chk("rst_hash", hash, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // all-zero frame
      run_frame("zero", 64'd0, 64'd0);
      accept("zero", 1'b0);

      // decreasing rows, then hash must hold in IDLE
      load(1);
      run_frame("dec", ALL_ONES, 64'd0);
      accept("dec", 1'b0);
      repeat (3) @(negedge clk);
      chk("idle_hash_hold", hash, ALL_ONES);

      // single bright pixel, then backpressure with ignored starts
      load(2);
      run_frame("bump", BUMP, ALL_ONES);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         start = (i == 2 || i == 6);
         @(negedge clk);
         start = 1'b0;
         if (!(hash_valid === 1'b1 && hash === BUMP && rd_en === 1'b0 && busy === 1'b1))
            bad++;
      end
      chk("bp_hold_bad", 64'(bad), 64'd0);
      accept("bp", 1'b1);
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (busy !== 1'b0 || rd_en !== 1'b0) bad++;
      end
      chk("start_at_handshake_ignored", 64'(bad), 64'd0);
      chk("bp_hash_kept", hash, BUMP);

      // reset in the middle of a frame
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (rd_addr === 7'd40) found = 1'b1;
      end
      chk("reach_addr40", {63'd0, found}, 64'd1);
      rst = 1'b0;
      #1;
      chk("midrst_outputs", {rd_en, rd_addr, busy, hash_valid}, 64'd0);
      chk("midrst_hash", hash, 64'd0);
      @(negedge clk);
      @(negedge clk);
      chk("in_rst_rd_en", {63'd0, rd_en}, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      load(0);
      run_frame("after_rst", 64'd0, 64'd0);
      accept("after_rst", 1'b0);

      // back-to-back frames, B with hash_ready held high (one-cycle valid)
      load(1);
      run_frame("frame_a", ALL_ONES, 64'd0);
      accept("frame_a", 1'b0);
      load(3);
      hash_ready = 1'b1;
      run_frame("frame_b", 64'd0, ALL_ONES);
      @(negedge clk);
      chk("b_one_cycle_valid", {63'd0, hash_valid}, 64'd0);
      chk("b_busy_clear", {63'd0, busy}, 64'd0);
      hash_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
